operand_issue_stage: RTL and testbench

- Parametrised decode-side operand stage: one pipeline slot between fetch and execute.
- Reads the register file combinationally from the slot's source addresses and resolves up to NUM_RD operands through priority forwarding from NUM_FWD downstream producers.
- Tracks outstanding long-latency writes (divide/multi-cycle ops) in a busy scoreboard.
- Stalls on not-yet-ready producers and exposes a saturating stall-cycle counter.

---
 rtl/operand_issue_stage.sv | 180 ++++++++++++++++++
 tb/tb_operand_issue_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue_stage.sv
// -----------------------------------------------------------------------------
// operand_issue_stage
//   Single decode-side pipeline slot between fetch and execute. Reads the
//   register file combinationally from the held source addresses, resolves
//   each source through priority forwarding (producer 0 = youngest wins), and
//   tracks outstanding long-latency writers in a 32-entry busy scoreboard.
//   Operands appear the same cycle the slot is valid and hazard-free.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   flush                 drop the slot contents on the next edge
//   in_valid/in_allowin   upstream handshake
//   in_payload/in_raddr/in_rneed/in_dest/in_long   instruction fields
//   rf_raddr/rf_rdata     register-file read port (address = held raddr)
//   fwd_we/fwd_waddr/fwd_wdata/fwd_rdy             downstream producers
//   lw_done/lw_waddr      long-latency writeback completion
//   out_valid/out_allowin downstream handshake
//   out_payload/out_dest/out_long/out_rdata        held fields, operands
//   stall_cnt             saturating count of stalled cycles
// -----------------------------------------------------------------------------
module operand_issue_stage #(
    parameter int XLEN        = 32,
    parameter int NUM_RD      = 2,
    parameter int NUM_FWD     = 3,
    parameter int PAYLOAD_W   = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_allowin,
    input  logic [PAYLOAD_W-1:0]     in_payload,
    input  logic [5*NUM_RD-1:0]      in_raddr,
    input  logic [NUM_RD-1:0]        in_rneed,
    input  logic [4:0]               in_dest,
    input  logic                     in_long,
    output logic [5*NUM_RD-1:0]      rf_raddr,
    input  logic [XLEN*NUM_RD-1:0]   rf_rdata,
    input  logic [NUM_FWD-1:0]       fwd_we,
    input  logic [5*NUM_FWD-1:0]     fwd_waddr,
    input  logic [XLEN*NUM_FWD-1:0]  fwd_wdata,
    input  logic [NUM_FWD-1:0]       fwd_rdy,
    input  logic                     lw_done,
    input  logic [4:0]               lw_waddr,
    output logic                     out_valid,
    input  logic                     out_allowin,
    output logic [PAYLOAD_W-1:0]     out_payload,
    output logic [4:0]               out_dest,
    output logic                     out_long,
    output logic [XLEN*NUM_RD-1:0]   out_rdata,
    output logic [STALL_CNT_W-1:0]   stall_cnt
);

    logic                    valid_q,     valid_d;
    logic [PAYLOAD_W-1:0]    payload_q,   payload_d;
    logic [5*NUM_RD-1:0]     raddr_q,     raddr_d;
    logic [NUM_RD-1:0]       rneed_q,     rneed_d;
    logic [4:0]              dest_q,      dest_d;
    logic                    long_q,      long_d;
    logic [31:0]             busy_q,      busy_d;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [NUM_RD-1:0]       port_stall;
    logic [XLEN*NUM_RD-1:0]  rdata_res;
    logic                    ready_go;
    logic                    handoff;

    // Operand resolution. The producer loop runs oldest to youngest so the
    // lowest-index match is the last assignment and therefore wins.
    always_comb begin : p_resolve
        logic [4:0]      src;
        logic            hit;
        logic            hit_rdy;
        logic [XLEN-1:0] data;
        port_stall = '0;
        rdata_res  = '0;
        src        = '0;
        hit        = 1'b0;
        hit_rdy    = 1'b1;
        data       = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            src     = raddr_q[5*i +: 5];
            hit     = 1'b0;
            hit_rdy = 1'b1;
            data    = rf_rdata[XLEN*i +: XLEN];
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
                if (fwd_we[j] && (fwd_waddr[5*j +: 5] == src)) begin
                    hit     = 1'b1;
                    hit_rdy = fwd_rdy[j];
                    data    = fwd_wdata[XLEN*j +: XLEN];
                end
            end
            if (src == 5'd0) begin
                data = '0;
            end else if (rneed_q[i]) begin
                if (hit) begin
                    port_stall[i] = !hit_rdy;
                end else begin
                    // A writeback completing this cycle lands in rf_rdata,
                    // so the busy bit no longer blocks.
                    port_stall[i] = busy_q[src] && !(lw_done && (lw_waddr == src));
                end
            end
            rdata_res[XLEN*i +: XLEN] = data;
        end
    end

    assign ready_go    = ~|port_stall;
    assign out_valid   = valid_q & ready_go;
    assign in_allowin  = !valid_q | (ready_go & out_allowin);
    assign handoff     = out_valid & out_allowin;

    assign rf_raddr    = raddr_q;
    assign out_payload = payload_q;
    assign out_dest    = dest_q;
    assign out_long    = long_q;
    assign out_rdata   = rdata_res;
    assign stall_cnt   = stall_cnt_q;

    always_comb begin : p_next
        valid_d     = valid_q;
        payload_d   = payload_q;
        raddr_d     = raddr_q;
        rneed_d     = rneed_q;
        dest_d      = dest_q;
        long_d      = long_q;
        busy_d      = busy_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (in_allowin) begin
            valid_d = in_valid;
            if (in_valid) begin
                payload_d = in_payload;
                raddr_d   = in_raddr;
                rneed_d   = in_rneed;
                dest_d    = in_dest;
                long_d    = in_long;
            end
        end

        // Clear first so a same-cycle set on the same register wins.
        if (lw_done) begin
            busy_d[lw_waddr] = 1'b0;
        end
        if (handoff && long_q && (dest_q != 5'd0)) begin
            busy_d[dest_q] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (valid_q && !ready_go && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            payload_q   <= '0;
            raddr_q     <= '0;
            rneed_q     <= '0;
            dest_q      <= '0;
            long_q      <= 1'b0;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            payload_q   <= payload_d;
            raddr_q     <= raddr_d;
            rneed_q     <= rneed_d;
            dest_q      <= dest_d;
            long_q      <= long_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_issue_stage
//   Directed scenarios with literal expectations, followed by a randomized
//   run. A behavioural slot/scoreboard model is checked against the DUT on
//   every cycle. The DUT is built with a 4-bit stall counter.
// -----------------------------------------------------------------------------
module tb_operand_issue_stage;

    localparam int XLEN = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_FWD = 3;
    localparam int PAYLOAD_W = 64;
    localparam int SCW = 4;
    localparam int SAT = (1 << SCW) - 1;

    logic clk = 1'b0;
    logic reset, flush, in_valid, in_allowin, in_long, lw_done, out_valid, out_allowin, out_long;
    logic [PAYLOAD_W-1:0] in_payload, out_payload;
    logic [5*NUM_RD-1:0] in_raddr, rf_raddr;
    logic [NUM_RD-1:0] in_rneed;
    logic [4:0] in_dest, lw_waddr, out_dest;
    logic [XLEN*NUM_RD-1:0] rf_rdata, out_rdata;
    logic [NUM_FWD-1:0] fwd_we, fwd_rdy;
    logic [5*NUM_FWD-1:0] fwd_waddr;
    logic [XLEN*NUM_FWD-1:0] fwd_wdata;
    logic [SCW-1:0] stall_cnt;

    operand_issue_stage #(.XLEN(XLEN), .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD),
                          .PAYLOAD_W(PAYLOAD_W), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_allowin(in_allowin),
        .in_payload(in_payload), .in_raddr(in_raddr), .in_rneed(in_rneed), .in_dest(in_dest),
        .in_long(in_long), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .fwd_we(fwd_we),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy), .lw_done(lw_done),
        .lw_waddr(lw_waddr), .out_valid(out_valid), .out_allowin(out_allowin),
        .out_payload(out_payload), .out_dest(out_dest), .out_long(out_long),
        .out_rdata(out_rdata), .stall_cnt(stall_cnt));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Behavioural model state
    bit                   m_valid;
    logic [PAYLOAD_W-1:0] m_payload;
    logic [4:0]           m_raddr [NUM_RD];
    bit                   m_rneed [NUM_RD];
    logic [4:0]           m_dest;
    bit                   m_long;
    bit                   m_busy [32];
    int                   m_stall;

    bit                   e_stall [NUM_RD];
    logic [XLEN-1:0]      e_data  [NUM_RD];
    bit                   e_ready, e_ov, e_allow;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_payload = '0; m_dest = '0; m_long = 0; m_stall = 0;
        for (int i = 0; i < NUM_RD; i++) begin m_raddr[i] = '0; m_rneed[i] = 0; end
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
    endtask

    // Outputs implied by the current model state and the present inputs.
    task automatic model_eval();
        e_ready = 1;
        for (int i = 0; i < NUM_RD; i++) begin
            int found = -1;
            logic [4:0] a = m_raddr[i];
            for (int j = 0; j < NUM_FWD; j++)
                if (found < 0 && fwd_we[j] && fwd_waddr[5*j +: 5] == a) found = j;
            e_stall[i] = 0;
            if (a == 0) begin
                e_data[i] = '0;
            end else if (found >= 0) begin
                e_data[i]  = fwd_wdata[XLEN*found +: XLEN];
                e_stall[i] = m_rneed[i] && !fwd_rdy[found];
            end else begin
                e_data[i]  = rf_rdata[XLEN*i +: XLEN];
                e_stall[i] = m_rneed[i] && m_busy[a] && !(lw_done && lw_waddr == a);
            end
            if (e_stall[i]) e_ready = 0;
        end
        e_ov    = m_valid && e_ready;
        e_allow = !m_valid || (e_ready && out_allowin);
    endtask

    task automatic model_check();
        model_eval();
        chk("in_allowin", 64'(in_allowin), 64'(e_allow));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        for (int i = 0; i < NUM_RD; i++) chk("rf_raddr", 64'(rf_raddr[5*i +: 5]), 64'(m_raddr[i]));
        if (m_valid) begin
            chk("out_payload", out_payload, m_payload);
            chk("out_dest", 64'(out_dest), 64'(m_dest));
            chk("out_long", 64'(out_long), 64'(m_long));
        end
        if (e_ov)
            for (int i = 0; i < NUM_RD; i++)
                if (m_rneed[i] || m_raddr[i] == 0)
                    chk("out_rdata", 64'(out_rdata[XLEN*i +: XLEN]), 64'(e_data[i]));
    endtask

    // State the model takes on at the coming clock edge.
    task automatic model_next();
        bit handoff;
        model_eval();
        handoff = e_ov && out_allowin;
        if (lw_done) m_busy[lw_waddr] = 0;
        if (handoff && m_long && m_dest != 0) m_busy[m_dest] = 1;
        if (m_valid && !e_ready && m_stall < SAT) m_stall++;
        if (flush) m_valid = 0;
        else if (e_allow) begin
            m_valid = in_valid;
            if (in_valid) begin
                m_payload = in_payload; m_dest = in_dest; m_long = in_long;
                for (int i = 0; i < NUM_RD; i++) begin
                    m_raddr[i] = in_raddr[5*i +: 5];
                    m_rneed[i] = in_rneed[i];
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        model_check();
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; in_payload = '0; in_raddr = '0; in_rneed = '0;
        in_dest = '0; in_long = 0; rf_rdata = '0; fwd_we = '0; fwd_waddr = '0;
        fwd_wdata = '0; fwd_rdy = '1; lw_done = 0; lw_waddr = '0; out_allowin = 1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic load(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] need,
                        input logic [4:0] dest, input bit lng);
        in_valid = 1; in_raddr = {a1, a0}; in_rneed = need; in_dest = dest; in_long = lng;
        in_payload = {$urandom, $urandom};
    endtask

    task automatic set_fwd(input int j, input bit we, input logic [4:0] a,
                           input logic [XLEN-1:0] d, input bit rdy);
        fwd_we[j] = we; fwd_waddr[5*j +: 5] = a; fwd_wdata[XLEN*j +: XLEN] = d; fwd_rdy[j] = rdy;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        model_reset();
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_allowin", 64'(in_allowin), 64'd1);
        chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
        chk("reset out_payload", out_payload, 64'd0);
        @(negedge clk); @(negedge clk);
        reset = 0;

        // No hazard
        load(5'd3, 5'd4, 2'b11, 5'd1, 0);
        tick();
        in_valid = 0; rf_rdata = {32'h22, 32'h11};
        #1;
        chk("nohaz out_valid", 64'(out_valid), 64'd1);
        chk("nohaz port0", 64'(out_rdata[31:0]), 64'h11);
        chk("nohaz port1", 64'(out_rdata[63:32]), 64'h22);
        chk("nohaz stall_cnt", 64'(stall_cnt), 64'd0);
        tick();

        // Priority forwarding
        clear_inputs();
        load(5'd5, 5'd0, 2'b01, 5'd2, 0);
        tick();
        clear_inputs();
        set_fwd(0, 1, 5'd5, 32'hAAAA, 1);
        set_fwd(2, 1, 5'd5, 32'hCCCC, 1);
        rf_rdata = {32'h5555, 32'h7777};
        #1;
        chk("prio port0", 64'(out_rdata[31:0]), 64'hAAAA);
        chk("prio r0", 64'(out_rdata[63:32]), 64'h0);
        tick();

        // Load-use
        do_reset();
        load(5'd7, 5'd0, 2'b01, 5'd3, 0);
        tick();
        clear_inputs();
        set_fwd(0, 1, 5'd7, 32'hDEAD, 0);
        #1;
        chk("lduse stall out_valid", 64'(out_valid), 64'd0);
        chk("lduse stall in_allowin", 64'(in_allowin), 64'd0);
        tick();
        set_fwd(0, 1, 5'd7, 32'h77, 1);
        #1;
        chk("lduse stall_cnt", 64'(stall_cnt), 64'd1);
        chk("lduse out_valid", 64'(out_valid), 64'd1);
        chk("lduse port0", 64'(out_rdata[31:0]), 64'h77);
        tick();

        // Scoreboard set / release
        do_reset();
        load(5'd0, 5'd0, 2'b00, 5'd9, 1);
        tick();
        load(5'd9, 5'd0, 2'b01, 5'd2, 0);
        #1;
        chk("sb long handoff", 64'(out_valid), 64'd1);
        chk("sb long dest", 64'(out_dest), 64'd9);
        tick();
        clear_inputs();
        #1;
        chk("sb consumer stalls", 64'(out_valid), 64'd0);
        tick();
        lw_done = 1; lw_waddr = 5'd9; rf_rdata = {32'h0, 32'h99};
        #1;
        chk("sb release out_valid", 64'(out_valid), 64'd1);
        chk("sb release port0", 64'(out_rdata[31:0]), 64'h99);
        tick();
        clear_inputs();

        // Same-cycle set and clear keeps the register busy
        do_reset();
        load(5'd0, 5'd0, 2'b00, 5'd9, 1);
        tick();
        load(5'd9, 5'd0, 2'b01, 5'd2, 0);
        lw_done = 1; lw_waddr = 5'd9;
        tick();
        clear_inputs();
        #1;
        chk("sb set wins", 64'(out_valid), 64'd0);
        tick();
        lw_done = 1; lw_waddr = 5'd9;
        tick();
        clear_inputs();

        // Flush while stalled
        do_reset();
        load(5'd7, 5'd0, 2'b01, 5'd3, 0);
        tick();
        clear_inputs();
        set_fwd(0, 1, 5'd7, 32'h1, 0);
        flush = 1;
        #1;
        chk("flush stalled", 64'(out_valid), 64'd0);
        tick();
        clear_inputs();
        #1;
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush in_allowin", 64'(in_allowin), 64'd1);
        tick();

        // Async reset mid-stall
        load(5'd7, 5'd0, 2'b01, 5'd3, 0);
        tick();
        clear_inputs();
        set_fwd(0, 1, 5'd7, 32'h1, 0);
        tick(); tick(); tick();
        #2;
        reset = 1;
        #1;
        chk("areset out_valid", 64'(out_valid), 64'd0);
        chk("areset stall_cnt", 64'(stall_cnt), 64'd0);
        chk("areset in_allowin", 64'(in_allowin), 64'd1);
        chk("areset out_dest", 64'(out_dest), 64'd0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        reset = 0;

        // Saturation
        load(5'd7, 5'd0, 2'b01, 5'd3, 0);
        tick();
        clear_inputs();
        set_fwd(0, 1, 5'd7, 32'h1, 0);
        for (int k = 0; k < 20; k++) tick();
        #1;
        chk("sat stall_cnt", 64'(stall_cnt), 64'd15);
        tick();

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) do_reset();
            flush       = ($urandom_range(15) == 0);
            in_valid    = $urandom_range(1);
            in_payload  = {$urandom, $urandom};
            for (int i = 0; i < NUM_RD; i++) in_raddr[5*i +: 5] = 5'($urandom_range(7));
            in_rneed    = NUM_RD'($urandom);
            in_dest     = 5'($urandom_range(7));
            in_long     = ($urandom_range(3) == 0);
            rf_rdata    = {$urandom, $urandom};
            for (int j = 0; j < NUM_FWD; j++)
                set_fwd(j, $urandom_range(1), 5'($urandom_range(7)), $urandom, ($urandom_range(3) != 0));
            lw_done     = ($urandom_range(3) == 0);
            lw_waddr    = 5'($urandom_range(7));
            out_allowin = ($urandom_range(3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
